// File: rtl/uart_tx_fifo.sv
// Byte-oriented UART transmitter (8N1) with a small input FIFO and a valid/ready write port.
// Define UART_TX_PARITY_EN to insert an even parity bit, making frames 8E1.
module uart_tx_fifo #(
  parameter logic [23:0] baud_rate  = 24'd4000000,
  parameter logic [27:0] clock_freq = 28'd50000000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic                          uart_clock,
  input  logic                          uart_reset,
  input  logic [7:0]                    uart_d_in,
  input  logic                          uart_valid_in,
  output logic                          uart_ready,
  output logic                          uart_d_out,
  output logic                          uart_busy,
  output logic [$clog2(FIFO_DEPTH):0]   uart_fifo_level
);

  localparam int BIT_CYCLES = int'(clock_freq / baud_rate);
  localparam int CNT_W      = $clog2(BIT_CYCLES);
  localparam int PTR_W      = $clog2(FIFO_DEPTH);
  localparam int LVL_W      = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_CYCLES - 1);
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_STOP   = 3'd3
`ifdef UART_TX_PARITY_EN
    ,
    ST_PARITY = 3'd4
`endif
  } state_t;

  logic [7:0]       fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [LVL_W-1:0] level;
  state_t           state;
  logic [CNT_W-1:0] cycle_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift_reg;
  logic             push;
  logic             pop;
  logic             bit_done;

  assign uart_ready      = (level != LVL_FULL);
  assign uart_fifo_level = level;
  assign uart_busy       = (state != ST_IDLE) || (level != '0);
  assign push            = uart_valid_in && uart_ready;
  assign bit_done        = (cycle_cnt == CNT_LAST);
  // The head is consumed from IDLE, or at stop-bit expiry so frames run back to back.
  assign pop             = (level != '0) &&
                           ((state == ST_IDLE) || ((state == ST_STOP) && bit_done));

  // Payload storage carries no reset; pointers and level define what is valid.
  always_ff @(posedge uart_clock) begin
    if (push) fifo_mem[wr_ptr] <= uart_d_in;
    if (pop)  shift_reg <= fifo_mem[rd_ptr];
  end

  always_ff @(posedge uart_clock) begin
    if (uart_reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      state      <= ST_IDLE;
      cycle_cnt  <= '0;
      bit_idx    <= '0;
      uart_d_out <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase

      case (state)
        ST_IDLE: begin
          cycle_cnt <= '0;
          bit_idx   <= '0;
          if (pop) begin
            uart_d_out <= 1'b0;
            state      <= ST_START;
          end else begin
            uart_d_out <= 1'b1;
          end
        end
        ST_START: begin
          if (bit_done) begin
            cycle_cnt  <= '0;
            bit_idx    <= '0;
            uart_d_out <= shift_reg[0];
            state      <= ST_DATA;
          end else begin
            cycle_cnt <= cycle_cnt + CNT_W'(1);
          end
        end
        ST_DATA: begin
          if (bit_done) begin
            cycle_cnt <= '0;
            if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              uart_d_out <= ^shift_reg;
              state      <= ST_PARITY;
`else
              uart_d_out <= 1'b1;
              state      <= ST_STOP;
`endif
            end else begin
              bit_idx    <= bit_idx + 3'd1;
              uart_d_out <= shift_reg[bit_idx + 3'd1];
            end
          end else begin
            cycle_cnt <= cycle_cnt + CNT_W'(1);
          end
        end
`ifdef UART_TX_PARITY_EN
        ST_PARITY: begin
          if (bit_done) begin
            cycle_cnt  <= '0;
            uart_d_out <= 1'b1;
            state      <= ST_STOP;
          end else begin
            cycle_cnt <= cycle_cnt + CNT_W'(1);
          end
        end
`endif
        ST_STOP: begin
          if (bit_done) begin
            cycle_cnt <= '0;
            bit_idx   <= '0;
            if (pop) begin
              uart_d_out <= 1'b0;
              state      <= ST_START;
            end else begin
              uart_d_out <= 1'b1;
              state      <= ST_IDLE;
            end
          end else begin
            cycle_cnt <= cycle_cnt + CNT_W'(1);
          end
        end
        default: begin
          uart_d_out <= 1'b1;
          state      <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: random and directed writes checked against a frame-schedule model.
module tb_uart_tx_fifo;
  localparam int BC    = 12;
  localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME = NBITS * BC;

  logic       uart_clock = 1'b0;
  logic       uart_reset = 1'b1;
  logic [7:0] uart_d_in = 8'h00;
  logic       uart_valid_in = 1'b0;
  logic       uart_ready;
  logic       uart_d_out;
  logic       uart_busy;
  logic [2:0] uart_fifo_level;

  uart_tx_fifo dut (
    .uart_clock      (uart_clock),
    .uart_reset      (uart_reset),
    .uart_d_in       (uart_d_in),
    .uart_valid_in   (uart_valid_in),
    .uart_ready      (uart_ready),
    .uart_d_out      (uart_d_out),
    .uart_busy       (uart_busy),
    .uart_fifo_level (uart_fifo_level)
  );

  always #5 uart_clock = ~uart_clock;

  // Each accepted byte owns a frame window [start, start+FRAME) on the line.
  typedef struct { int start; logic [7:0] data; } frame_t;
  frame_t frames[$];
  int   cyc = 0;
  int   last_start = 0;
  bit   have_last = 0;
  int   total = 0;
  int   bad = 0;
  logic acc;
  logic exp_dout, exp_busy, exp_ready;
  int   exp_level;

  function automatic int m_level(input int c);
    int n = 0;
    foreach (frames[i]) if (frames[i].start > c) n++;
    return n;
  endfunction

  function automatic logic m_dout(input int c);
    foreach (frames[i]) begin
      if (c >= frames[i].start && c < frames[i].start + FRAME) begin
        int k = (c - frames[i].start) / BC;
        if (k == 0) return 1'b0;
        if (k <= 8) return frames[i].data[k-1];
        if (NBITS == 11 && k == 9) return ^frames[i].data;
        return 1'b1;
      end
    end
    return 1'b1;
  endfunction

  function automatic logic m_busy(input int c);
    foreach (frames[i]) if (frames[i].start + FRAME > c) return 1'b1;
    return 1'b0;
  endfunction

  task automatic step(input logic rst, input logic v, input logic [7:0] d);
    int st;
    uart_reset    = rst;
    uart_valid_in = v;
    uart_d_in     = d;
    acc = v && !rst && (m_level(cyc) != DEPTH);
    @(posedge uart_clock);
    cyc++;
    if (rst) begin
      frames.delete();
      have_last = 0;
    end else if (acc) begin
      st = cyc + 1;
      if (have_last && last_start + FRAME > st) st = last_start + FRAME;
      frames.push_back('{start: st, data: d});
      last_start = st;
      have_last  = 1;
    end
    while (frames.size() > 0 && frames[0].start + FRAME <= cyc) void'(frames.pop_front());
    exp_dout  = m_dout(cyc);
    exp_busy  = m_busy(cyc);
    exp_level = m_level(cyc);
    exp_ready = (exp_level != DEPTH);
    #1;
  endtask

  task automatic test_reset();
    step(1'b1, 1'b0, 8'h00);
    step(1'b1, 1'b1, 8'h5A);
    for (int i = 0; i < 50; i++) begin
      step(1'b0, 1'b0, 8'h00);
      total++; if (uart_d_out !== 1'b1) begin bad++; $display("FAIL reset_dout cyc=%0d got=%b exp=1", cyc, uart_d_out); end
      total++; if (uart_ready !== 1'b1) begin bad++; $display("FAIL reset_ready cyc=%0d got=%b exp=1", cyc, uart_ready); end
      total++; if (uart_busy !== 1'b0) begin bad++; $display("FAIL reset_busy cyc=%0d got=%b exp=0", cyc, uart_busy); end
      total++; if (uart_fifo_level !== 3'd0) begin bad++; $display("FAIL reset_level cyc=%0d got=%0d exp=0", cyc, uart_fifo_level); end
    end
  endtask

  task automatic test_single();
    int e;
    step(1'b0, 1'b1, 8'hA5);
    e = cyc;
    for (int i = 0; i < FRAME + 10; i++) begin
      step(1'b0, 1'b0, 8'hFF);
      total++; if (uart_d_out !== exp_dout) begin bad++; $display("FAIL single_dout cyc=%0d got=%b exp=%b", cyc, uart_d_out, exp_dout); end
      total++; if (uart_busy !== exp_busy) begin bad++; $display("FAIL single_busy cyc=%0d got=%b exp=%b", cyc, uart_busy, exp_busy); end
      if (cyc == e + 1) begin
        total++; if (uart_d_out !== 1'b0) begin bad++; $display("FAIL single_latency cyc=%0d got=%b exp=0", cyc, uart_d_out); end
      end
      if (cyc == e + FRAME + 1) begin
        total++; if (uart_busy !== 1'b0) begin bad++; $display("FAIL single_busy_end cyc=%0d got=%b exp=0", cyc, uart_busy); end
      end
    end
  endtask

  task automatic test_burst();
    logic [7:0] burst [5];
    int idx = 0;
    burst = '{8'h00, 8'hFF, 8'h3C, 8'h81, 8'h55};
    for (int i = 0; i < 5 * FRAME + 20; i++) begin
      if (idx < 5) step(1'b0, 1'b1, burst[idx]);
      else         step(1'b0, 1'b0, 8'h00);
      if (acc) idx++;
      total++; if (uart_d_out !== exp_dout) begin bad++; $display("FAIL burst_dout cyc=%0d got=%b exp=%b", cyc, uart_d_out, exp_dout); end
      total++; if (uart_ready !== exp_ready) begin bad++; $display("FAIL burst_ready cyc=%0d got=%b exp=%b", cyc, uart_ready, exp_ready); end
      total++; if (uart_fifo_level !== 3'(exp_level)) begin bad++; $display("FAIL burst_level cyc=%0d got=%0d exp=%0d", cyc, uart_fifo_level, exp_level); end
      total++; if (uart_busy !== exp_busy) begin bad++; $display("FAIL burst_busy cyc=%0d got=%b exp=%b", cyc, uart_busy, exp_busy); end
    end
    total++; if (idx !== 5) begin bad++; $display("FAIL burst_accepted got=%0d exp=5", idx); end
  endtask

  task automatic test_push_pop();
    int tgt;
    step(1'b0, 1'b1, 8'h34);
    step(1'b0, 1'b1, 8'h56);
    tgt = last_start;
    while (cyc + 1 < tgt) begin
      step(1'b0, 1'b0, 8'h00);
      total++; if (uart_d_out !== exp_dout) begin bad++; $display("FAIL pushpop_dout cyc=%0d got=%b exp=%b", cyc, uart_d_out, exp_dout); end
    end
    step(1'b0, 1'b1, 8'h12);
    total++; if (uart_fifo_level !== 3'd1) begin bad++; $display("FAIL pushpop_level cyc=%0d got=%0d exp=1", cyc, uart_fifo_level); end
    total++; if (uart_d_out !== 1'b0) begin bad++; $display("FAIL pushpop_start cyc=%0d got=%b exp=0", cyc, uart_d_out); end
    for (int i = 0; i < 2 * FRAME + 5; i++) begin
      step(1'b0, 1'b0, 8'hEE);
      total++; if (uart_d_out !== exp_dout) begin bad++; $display("FAIL pushpop_dout cyc=%0d got=%b exp=%b", cyc, uart_d_out, exp_dout); end
      total++; if (uart_fifo_level !== 3'(exp_level)) begin bad++; $display("FAIL pushpop_level cyc=%0d got=%0d exp=%0d", cyc, uart_fifo_level, exp_level); end
    end
  endtask

  task automatic test_reset_mid();
    int s;
    step(1'b0, 1'b1, 8'hC3);
    s = last_start;
    step(1'b0, 1'b1, 8'h11);
    step(1'b0, 1'b1, 8'h22);
    while (cyc + 1 < s + 40) step(1'b0, 1'b0, 8'h00);
    total++; if (uart_fifo_level !== 3'd2) begin bad++; $display("FAIL midreset_prelevel got=%0d exp=2", uart_fifo_level); end
    step(1'b1, 1'b0, 8'h00);
    total++; if (uart_d_out !== 1'b1) begin bad++; $display("FAIL midreset_dout got=%b exp=1", uart_d_out); end
    total++; if (uart_fifo_level !== 3'd0) begin bad++; $display("FAIL midreset_level got=%0d exp=0", uart_fifo_level); end
    for (int i = 0; i < 3 * FRAME; i++) begin
      step(1'b0, 1'b0, 8'h00);
      total++; if (uart_d_out !== 1'b1) begin bad++; $display("FAIL midreset_idle cyc=%0d got=%b exp=1", cyc, uart_d_out); end
      total++; if (uart_busy !== 1'b0) begin bad++; $display("FAIL midreset_busy cyc=%0d got=%b exp=0", cyc, uart_busy); end
    end
  endtask

  task automatic test_random();
    int n = 0;
    for (int i = 0; i < 14 * FRAME; i++) begin
      step(1'b0, ($urandom_range(0, 15) == 0), 8'($urandom));
      if (acc) n++;
      total++; if (uart_d_out !== exp_dout) begin bad++; $display("FAIL rand_dout cyc=%0d got=%b exp=%b", cyc, uart_d_out, exp_dout); end
      total++; if (uart_fifo_level !== 3'(exp_level)) begin bad++; $display("FAIL rand_level cyc=%0d got=%0d exp=%0d", cyc, uart_fifo_level, exp_level); end
      total++; if (uart_ready !== exp_ready) begin bad++; $display("FAIL rand_ready cyc=%0d got=%b exp=%b", cyc, uart_ready, exp_ready); end
      total++; if (uart_busy !== exp_busy) begin bad++; $display("FAIL rand_busy cyc=%0d got=%b exp=%b", cyc, uart_busy, exp_busy); end
    end
    for (int i = 0; i < DEPTH * FRAME + FRAME; i++) begin
      step(1'b0, 1'b0, 8'h00);
      total++; if (uart_d_out !== exp_dout) begin bad++; $display("FAIL rand_drain cyc=%0d got=%b exp=%b", cyc, uart_d_out, exp_dout); end
    end
    total++; if (uart_busy !== 1'b0) begin bad++; $display("FAIL rand_final_busy got=%b exp=0 accepted=%0d", uart_busy, n); end
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity();
    int s;
    step(1'b0, 1'b1, 8'h07);
    s = last_start;
    step(1'b0, 1'b1, 8'h03);
    for (int i = 0; i < 2 * FRAME + 5; i++) begin
      step(1'b0, 1'b0, 8'h00);
      total++; if (uart_d_out !== exp_dout) begin bad++; $display("FAIL parity_dout cyc=%0d got=%b exp=%b", cyc, uart_d_out, exp_dout); end
      if (cyc == s + 9 * BC) begin
        total++; if (uart_d_out !== 1'b1) begin bad++; $display("FAIL parity_07 got=%b exp=1", uart_d_out); end
      end
      if (cyc == s + FRAME + 9 * BC) begin
        total++; if (uart_d_out !== 1'b0) begin bad++; $display("FAIL parity_03 got=%b exp=0", uart_d_out); end
      end
    end
  endtask
`endif

  initial begin
    #2;
    test_reset();
    test_single();
    test_burst();
    test_push_pop();
    test_reset_mid();
    test_random();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Byte-oriented UART transmitter with a small input FIFO. It is the transmit-side counterpart of the UART receiver in the encryption datapath.
- Core logic pushes bytes through a valid/ready handshake. The block serialises each byte as 8N1 (8 data bits, no parity, 1 stop bit) on a single line, which idles high.
- It carries the AES result bytes back to the host at the same baud and clock parameters as the receive path.

Parameters:
- baud_rate, 24'd4000000, serial bit rate in bits/s.
- clock_freq, 28'd50000000, uart_clock frequency in Hz.
- FIFO_DEPTH, 4, input FIFO entries. Must be a power of two, minimum 2.
- Derived BIT_CYCLES = clock_freq / baud_rate, integer-truncated (12 at the defaults). Must be at least 2.

Ports:
- uart_clock  input  1  system clock; all logic on its rising edge.
- uart_reset  input  1  reset, synchronous, active-high.
- uart_d_in  input  8  byte to transmit.
- uart_valid_in  input  1  uart_d_in is valid this cycle.
- uart_ready  output  1  FIFO can accept a byte this cycle.
- uart_d_out  output  1  serial TX line, registered, idle high.
- uart_busy  output  1  a frame is being transmitted, or the FIFO is non-empty.
- uart_fifo_level  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset is sampled on the uart_clock edge, synchronous and active-high. It overrides everything else.
  - Reset values: uart_d_out=1, uart_ready=1, uart_busy=0, uart_fifo_level=0.
  - FIFO pointers cleared; state=IDLE; bit and cycle counters cleared.
- Write handshake:
  - A byte is accepted on an edge where uart_valid_in && uart_ready.
  - uart_ready = (level != FIFO_DEPTH), combinational from the registered level.
  - A write attempted while full is ignored and leaves no side effect.
- FIFO:
  - Circular buffer with wrap-around read and write pointers; first in, first out.
  - Push and pop on the same edge leave the level unchanged and keep the data order.
- States and transitions:
  - IDLE: uart_d_out=1. If level>0, pop the head into the 8-bit shift register, register uart_d_out<=0 and go to START.
  - START: hold for BIT_CYCLES cycles, then drive data bit 0 and go to DATA.
  - DATA: 8 bits, LSB first, each held BIT_CYCLES cycles. A 3-bit index selects the bit. After bit 7 expires go to STOP (or PARITY when the optional feature is compiled in).
  - STOP: drive 1 for BIT_CYCLES cycles. On expiry, if level>0, pop and go straight to START with no idle gap between frames; otherwise go to IDLE.
- Cycle counter runs 0..BIT_CYCLES-1 and reloads to 0 on every bit boundary. The counter width is sized so the counter never wraps.
- Latency: byte accepted at edge E with the FIFO empty and state IDLE gives uart_d_out=0 after edge E+1.
- Frame length: exactly 10*BIT_CYCLES cycles per frame (11*BIT_CYCLES with parity).
- uart_busy = (state != IDLE) || (level != 0).
- Reset asserted mid-frame: uart_d_out returns to 1 on that same edge. Partially sent and queued bytes are discarded.
- uart_d_in is captured only at acceptance. Later changes to it do not affect queued bytes.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - A PARITY state is inserted between DATA and STOP. It drives the even parity bit (XOR of the 8 data bits) for BIT_CYCLES cycles.
  - The frame becomes 11 bits (8E1).
- Undefined:
  - The PARITY state and its logic are absent; frames are 8N1.

Test Plan:
- Reset then idle 50 cycles -> uart_d_out=1, uart_ready=1, uart_busy=0, uart_fifo_level=0 throughout.
- Single byte 0xA5 at defaults (BIT_CYCLES=12) -> 12 cycles each of 0,1,0,1,0,0,1,0,1,1 (120 cycles total); start bit begins one edge after acceptance; uart_busy drops the cycle after the stop bit ends.
- Burst of 0x00,0xFF,0x3C,0x81,0x55 with uart_valid_in held high -> the first 4 (or 5, with a concurrent pop) are accepted; uart_ready low while level=4; all bytes emitted in order with consecutive frames and no idle gap.
- Simultaneous push and pop (write 0x12 on the exact STOP-expiry edge with level=1) -> level stays 1; 0x12 is transmitted after the byte already queued; pointers wrap correctly after 8+ transfers.
- Reset asserted at cycle 40 of frame 0xC3 with 2 queued bytes -> uart_d_out=1 and uart_fifo_level=0 after that edge; no further frames until new writes.
- With UART_TX_PARITY_EN, byte 0x07 -> parity bit 1 and frame length 132 cycles; byte 0x03 -> parity bit 0.
